// File: rtl/axi_default_slave_pkg.sv
// Shared AXI widths and response codes for the default (DECERR) slave.
`default_nettype none
package axi_default_slave_pkg;
  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 8;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_STRB_BITS = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
endpackage
`default_nettype wire

// File: rtl/axi_default_slave_sd_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
`default_nettype none
module sd_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_default_slave.sv
// AXI4 default slave: completes every unmapped read/write burst with DECERR
// and counts the terminated transactions.
`default_nettype none
module axi_default_slave
  import axi_default_slave_pkg::*;
#(
  parameter logic [31:0] RDATA_FILL = 32'h0000_0000,
  parameter int          CNT_BITS   = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [AXI_IDS_BITS-1:0]  AWID,
  input  logic [AXI_ADDR_BITS-1:0] AWADDR,
  input  logic [AXI_LEN_BITS-1:0]  AWLEN,
  input  logic [2:0]               AWSIZE,
  input  logic [1:0]               AWBURST,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [AXI_DATA_BITS-1:0] WDATA,
  input  logic [AXI_STRB_BITS-1:0] WSTRB,
  input  logic                     WLAST,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [AXI_IDS_BITS-1:0]  BID,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [AXI_IDS_BITS-1:0]  ARID,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN,
  input  logic [2:0]               ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [AXI_IDS_BITS-1:0]  RID,
  output logic [AXI_DATA_BITS-1:0] RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [CNT_BITS-1:0]      WR_ERR_CNT,
  output logic [CNT_BITS-1:0]      RD_ERR_CNT
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [AXI_IDS_BITS-1:0] bid_q;
  logic [AXI_IDS_BITS-1:0] rid_q;
  logic [AXI_LEN_BITS-1:0] rlen_q;
  logic [AXI_LEN_BITS-1:0] beat_q;

  logic awready_int, wready_int, bvalid_int, wr_done;
  logic arready_int, rvalid_int, rlast_int, rd_done;

  // Address, size, burst and write data carry no meaning for a DECERR responder.
  logic unused_inputs;
  assign unused_inputs = ^{AWADDR, AWLEN, AWSIZE, AWBURST, WDATA, WSTRB,
                           ARADDR, ARSIZE, ARBURST};

  // ---------------- write path ----------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      bid_q   <= '0;
    end else begin
      w_state <= w_next;
      if ((w_state == W_IDLE) && AWVALID) begin
        bid_q <= AWID;
      end
    end
  end

  always_comb begin
    w_next      = w_state;
    awready_int = 1'b0;
    wready_int  = 1'b0;
    bvalid_int  = 1'b0;
    wr_done     = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready_int = 1'b1;
        // A W beat is only taken together with its AW so the ID is never lost.
        wready_int  = AWVALID;
        if (AWVALID) begin
          w_next = (WVALID && WLAST) ? W_RESP : W_DATA;
        end
      end
      W_DATA: begin
        wready_int = 1'b1;
        if (WVALID && WLAST) begin
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        bvalid_int = 1'b1;
        if (BREADY) begin
          w_next  = W_IDLE;
          wr_done = 1'b1;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign AWREADY = awready_int & ~ARESET;
  assign WREADY  = wready_int & ~ARESET;
  assign BVALID  = bvalid_int;
  assign BID     = bvalid_int ? bid_q : '0;
  assign BRESP   = bvalid_int ? AXI_RESP_DECERR : AXI_RESP_OKAY;

  // ---------------- read path ----------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      rid_q   <= '0;
      rlen_q  <= '0;
      beat_q  <= '0;
    end else begin
      r_state <= r_next;
      if ((r_state == R_IDLE) && ARVALID) begin
        rid_q  <= ARID;
        rlen_q <= ARLEN;
        beat_q <= '0;
      end else if ((r_state == R_DATA) && RREADY) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  always_comb begin
    r_next      = r_state;
    arready_int = 1'b0;
    rvalid_int  = 1'b0;
    rlast_int   = 1'b0;
    rd_done     = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready_int = 1'b1;
        if (ARVALID) begin
          r_next = R_DATA;
        end
      end
      R_DATA: begin
        rvalid_int = 1'b1;
        rlast_int  = (beat_q == rlen_q);
        if (RREADY && rlast_int) begin
          r_next  = R_IDLE;
          rd_done = 1'b1;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign ARREADY = arready_int & ~ARESET;
  assign RVALID  = rvalid_int;
  assign RLAST   = rlast_int;
  assign RID     = rvalid_int ? rid_q : '0;
  assign RDATA   = rvalid_int ? RDATA_FILL : '0;
  assign RRESP   = rvalid_int ? AXI_RESP_DECERR : AXI_RESP_OKAY;

  // ---------------- error counters ----------------
  sd_sat_cnt #(.WIDTH(CNT_BITS)) u_wr_cnt (
    .clk   (ACLK),
    .rst   (ARESET),
    .inc   (wr_done),
    .clear (1'b0),
    .count (WR_ERR_CNT)
  );

  sd_sat_cnt #(.WIDTH(CNT_BITS)) u_rd_cnt (
    .clk   (ACLK),
    .rst   (ARESET),
    .inc   (rd_done),
    .clear (1'b0),
    .count (RD_ERR_CNT)
  );

endmodule
`default_nettype wire

// File: tb/tb_axi_default_slave.sv
// Bench for axi_default_slave: table of transactions plus scoreboarded R/B channels.
`default_nettype none
module tb_axi_default_slave;

  localparam logic [31:0] FILL = 32'hA5A5_0F0F;
  localparam int          CB   = 3;
  localparam int          CMAX = 7;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [CB-1:0] WR_ERR_CNT, RD_ERR_CNT;

  axi_default_slave #(.RDATA_FILL(FILL), .CNT_BITS(CB)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .WR_ERR_CNT(WR_ERR_CNT), .RD_ERR_CNT(RD_ERR_CNT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [7:0] id;
    logic       last;
  } rexp_t;

  typedef struct {
    bit          is_rd;
    logic [7:0]  id;
    int          len;
    int          bdelay;
    logic [31:0] rpat;
    int          exp_wr;
    int          exp_rd;
  } vec_t;

  rexp_t      rq[$];
  logic [7:0] bq[$];
  int         total = 0;
  int         bad   = 0;
  int         exp_wr = 0;
  int         exp_rd = 0;
  rexp_t      me;
  logic [7:0] mb;
  vec_t       vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  // Scoreboard: pops the expected beat/response whenever a handshake is visible.
  always @(negedge ACLK) begin
    if (ARESET) begin
      chk("rst_rvalid", {31'd0, RVALID}, 0);
      chk("rst_bvalid", {31'd0, BVALID}, 0);
      chk("rst_ready", {29'd0, AWREADY, WREADY, ARREADY}, 0);
      chk("rst_cnt", {26'd0, WR_ERR_CNT, RD_ERR_CNT}, 0);
      rq.delete();
      bq.delete();
      exp_wr = 0;
      exp_rd = 0;
    end else begin
      chk("wr_cnt", {29'd0, WR_ERR_CNT}, exp_wr);
      chk("rd_cnt", {29'd0, RD_ERR_CNT}, exp_rd);
      if (!RVALID) chk("r_idle_zero", RDATA | {24'd0, RID} | {30'd0, RRESP}, 0);
      if (!BVALID) chk("b_idle_zero", {22'd0, BID, BRESP}, 0);
      if (RVALID && RREADY) begin
        if (rq.size() == 0) begin
          chk("r_unexpected", 1, 0);
        end else begin
          me = rq.pop_front();
          chk("rid", {24'd0, RID}, {24'd0, me.id});
          chk("rdata", RDATA, FILL);
          chk("rresp", {30'd0, RRESP}, 3);
          chk("rlast", {31'd0, RLAST}, {31'd0, me.last});
          if (me.last && exp_rd < CMAX) exp_rd++;
        end
      end
      if (BVALID && BREADY) begin
        if (bq.size() == 0) begin
          chk("b_unexpected", 1, 0);
        end else begin
          mb = bq.pop_front();
          chk("bid", {24'd0, BID}, {24'd0, mb});
          chk("bresp", {30'd0, BRESP}, 3);
          if (exp_wr < CMAX) exp_wr++;
        end
      end
    end
  end

  task automatic do_write(input logic [7:0] id, input int len, input int bdelay);
    bq.push_back(id);
    AWVALID = 1'b1; AWID = id; AWLEN = len[7:0]; AWADDR = $urandom;
    WVALID = (len == 0); WLAST = (len == 0); WDATA = $urandom;
    #1;
    chk("awready_idle", {31'd0, AWREADY}, 1);
    chk("wready_with_aw", {31'd0, WREADY}, 1);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
    if (len > 0) begin
      #1;
      chk("wready_after_aw", {31'd0, WREADY}, 1);
      chk("awready_wdata", {31'd0, AWREADY}, 0);
      for (int b = 0; b <= len; b++) begin
        WVALID = 1'b1; WLAST = (b == len); WDATA = $urandom;
        tick();
      end
      WVALID = 1'b0; WLAST = 1'b0;
    end
    #1;
    chk("bvalid_after_wlast", {31'd0, BVALID}, 1);
    for (int d = 0; d < bdelay; d++) begin
      chk("b_hold", {31'd0, BVALID}, 1);
      chk("bid_hold", {24'd0, BID}, {24'd0, id});
      chk("awready_bwait", {31'd0, AWREADY}, 0);
      tick();
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("b_done", {31'd0, BVALID}, 0);
  endtask

  task automatic do_read(input logic [7:0] id, input int len, input logic [31:0] rpat);
    int    guard;
    rexp_t e;
    for (int b = 0; b <= len; b++) begin
      e.id = id; e.last = (b == len);
      rq.push_back(e);
    end
    ARVALID = 1'b1; ARID = id; ARLEN = len[7:0]; ARADDR = $urandom; RREADY = 1'b0;
    #1;
    chk("arready_idle", {31'd0, ARREADY}, 1);
    tick();
    ARVALID = 1'b0;
    #1;
    chk("rvalid_after_ar", {31'd0, RVALID}, 1);
    chk("arready_busy", {31'd0, ARREADY}, 0);
    guard = 0;
    while (rq.size() != 0 && guard < 200) begin
      RREADY = rpat[guard % 32];
      tick();
      guard++;
    end
    RREADY = 1'b0;
    if (rq.size() != 0) chk("r_timeout", 1, 0);
    chk("arready_after_rlast", {31'd0, ARREADY}, 1);
    chk("rvalid_after_rlast", {31'd0, RVALID}, 0);
  endtask

  initial begin
    vecs[0]  = '{0, 8'h15, 0, 0, 32'hFFFF_FFFF, 1, 0};
    vecs[1]  = '{0, 8'h22, 3, 3, 32'hFFFF_FFFF, 2, 0};
    vecs[2]  = '{1, 8'h07, 3, 0, 32'hFFFF_FFFF, 2, 1};
    vecs[3]  = '{1, 8'h31, 2, 0, 32'h5555_5555, 2, 2};
    vecs[4]  = '{0, 8'hAA, 1, 1, 32'hFFFF_FFFF, 3, 2};
    vecs[5]  = '{1, 8'hFF, 0, 0, 32'hFFFF_FFFF, 3, 3};
    vecs[6]  = '{1, 8'h40, 7, 0, 32'h3333_3333, 3, 4};
    vecs[7]  = '{0, 8'h41, 0, 2, 32'hFFFF_FFFF, 4, 4};
    vecs[8]  = '{0, 8'h42, 5, 0, 32'hFFFF_FFFF, 5, 4};
    vecs[9]  = '{1, 8'h43, 1, 0, 32'hFFFF_FFFF, 5, 5};
    vecs[10] = '{0, 8'h44, 0, 0, 32'hFFFF_FFFF, 6, 5};
    vecs[11] = '{1, 8'h45, 0, 0, 32'hFFFF_FFFF, 6, 6};
    vecs[12] = '{0, 8'h46, 2, 1, 32'hFFFF_FFFF, 7, 6};
    vecs[13] = '{1, 8'h47, 1, 0, 32'hFFFF_FFFF, 7, 7};
    vecs[14] = '{0, 8'h48, 0, 0, 32'hFFFF_FFFF, 7, 7};
    vecs[15] = '{1, 8'h49, 0, 0, 32'hFFFF_FFFF, 7, 7};

    ARESET = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = '0; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0;
    RREADY = 1'b0;
    repeat (2) tick();
    ARESET = 1'b0;
    #1;
    chk("post_rst_awready", {31'd0, AWREADY}, 1);
    chk("post_rst_arready", {31'd0, ARREADY}, 1);
    chk("post_rst_wready_no_aw", {31'd0, WREADY}, 0);
    tick();

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_rd) do_read(vecs[i].id, vecs[i].len, vecs[i].rpat);
      else               do_write(vecs[i].id, vecs[i].len, vecs[i].bdelay);
      chk("vec_wr_cnt", {29'd0, WR_ERR_CNT}, vecs[i].exp_wr);
      chk("vec_rd_cnt", {29'd0, RD_ERR_CNT}, vecs[i].exp_rd);
      tick();
    end

    // RREADY 1,0,1 on a two-beat burst: the stall must hold RLAST.
    begin
      rexp_t e;
      e.id = 8'h5C; e.last = 1'b0; rq.push_back(e);
      e.last = 1'b1; rq.push_back(e);
      ARVALID = 1'b1; ARID = 8'h5C; ARLEN = 8'd1;
      tick();
      ARVALID = 1'b0; RREADY = 1'b1;
      #1 chk("stall_beat1_rlast", {31'd0, RLAST}, 0);
      tick();
      RREADY = 1'b0;
      #1 chk("stall_rvalid", {31'd0, RVALID}, 1);
      chk("stall_rlast", {31'd0, RLAST}, 1);
      tick();
      RREADY = 1'b1;
      #1 chk("stall_beat2_rlast", {31'd0, RLAST}, 1);
      tick();
      RREADY = 1'b0;
      chk("stall_done", {31'd0, RVALID}, 0);
      chk("stall_q_empty", rq.size(), 0);
    end
    tick();

    // Reset in the middle of an eight-beat read abandons it without a response.
    begin
      rexp_t e;
      for (int b = 0; b < 8; b++) begin
        e.id = 8'h66; e.last = (b == 7); rq.push_back(e);
      end
      ARVALID = 1'b1; ARID = 8'h66; ARLEN = 8'd7;
      tick();
      ARVALID = 1'b0; RREADY = 1'b1;
      repeat (2) tick();
      ARESET = 1'b1;
      #1;
      chk("rst_mid_rvalid", {31'd0, RVALID}, 0);
      chk("rst_mid_rlast", {31'd0, RLAST}, 0);
      tick();
      RREADY = 1'b0;
      ARESET = 1'b0;
      #1 chk("rst_mid_cnt", {26'd0, WR_ERR_CNT, RD_ERR_CNT}, 0);
      tick();
      do_read(8'h67, 0, 32'hFFFF_FFFF);
      chk("after_rst_rd_cnt", {29'd0, RD_ERR_CNT}, 1);
    end
    tick();

    // Concurrent read and single-beat write: both counters step together.
    begin
      rexp_t e;
      e.id = 8'h71; e.last = 1'b1; rq.push_back(e);
      bq.push_back(8'h72);
      ARVALID = 1'b1; ARID = 8'h71; ARLEN = 8'd0;
      AWVALID = 1'b1; AWID = 8'h72; AWLEN = 8'd0; WVALID = 1'b1; WLAST = 1'b1;
      tick();
      ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
      #1;
      chk("conc_rvalid", {31'd0, RVALID}, 1);
      chk("conc_bvalid", {31'd0, BVALID}, 1);
      RREADY = 1'b1; BREADY = 1'b1;
      tick();
      RREADY = 1'b0; BREADY = 1'b0;
      chk("conc_wr_cnt", {29'd0, WR_ERR_CNT}, 1);
      chk("conc_rd_cnt", {29'd0, RD_ERR_CNT}, 2);
    end
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/axi_default_slave.md
# axi_default_slave

AXI4 default slave (DECERR responder) that terminates every transaction the bus decoder cannot map to a real slave. It sits directly downstream of the read/write arbitration FSMs: when a granted master's address decodes to no slave, the crossbar routes that master's AW/W/B or AR/R channels here. The block completes the transaction protocol-correctly with a DECERR response so the master never hangs. Read and write paths are independent and may be active simultaneously.

## Interface
Parameters:
- RDATA_FILL, 32'h0000_0000, value driven on RDATA for every read beat
- CNT_BITS, 16, width of the saturating error counters

Ports (widths from AXI_define.svh):
- ACLK  in  1  bus clock, all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- AWID  in  AXI_IDS_BITS  write address ID
- AWADDR  in  AXI_ADDR_BITS  ignored except for debug
- AWLEN  in  AXI_LEN_BITS  burst length − 1
- AWSIZE / AWBURST  in  3 / 2  ignored
- AWVALID / AWREADY  in / out  1  AW handshake
- WDATA / WSTRB  in  32 / 4  discarded
- WLAST / WVALID / WREADY  in / in / out  1  W handshake
- BID  out  AXI_IDS_BITS  echoes latched AWID
- BRESP  out  2  always DECERR (2'b11) while BVALID
- BVALID / BREADY  out / in  1  B handshake
- ARID / ARADDR / ARLEN / ARSIZE / ARBURST  in  as AW  read address fields
- ARVALID / ARREADY  in / out  1  AR handshake
- RID  out  AXI_IDS_BITS  echoes latched ARID
- RDATA  out  32  RDATA_FILL
- RRESP  out  2  DECERR while RVALID
- RLAST / RVALID / RREADY  out / out / in  1  R handshake
- WR_ERR_CNT / RD_ERR_CNT  out  CNT_BITS  completed DECERR write/read transactions, saturating

## Operation
- Write FSM, states W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1; WREADY=AWVALID (accepts a W beat only alongside AW). On AW handshake, latch AWID.
    - If a W handshake with WLAST occurs in the same cycle, go to W_RESP.
    - Otherwise go to W_DATA.
  - W_DATA: WREADY=1, AWREADY=0. Beats are discarded. A W handshake with WLAST goes to W_RESP. WLAST alone terminates the burst; a beat count mismatch against AWLEN is not checked.
  - W_RESP: BVALID=1, BRESP=2'b11, BID=latched ID. On BREADY, go to W_IDLE and increment WR_ERR_CNT.
- Read FSM, states R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On AR handshake, latch ARID and ARLEN, clear the beat counter, go to R_DATA.
  - R_DATA: RVALID=1, RDATA=RDATA_FILL, RRESP=2'b11, RID=latched ID, RLAST=(beat==latched LEN).
    - Each RVALID&&RREADY increments the beat counter.
    - The handshake on the RLAST beat goes to R_IDLE and increments RD_ERR_CNT.
- Counters saturate at all-ones and never wrap.
- BID/RID/RDATA/BRESP/RRESP are 0 whenever their VALID is 0.

## Timing
- Reset values: all VALID/READY/LAST outputs 0, IDs 0, counters 0, both FSMs in IDLE. READY outputs are forced 0 while ARESET is high.
- Reset asserted mid-transaction: immediate return to IDLE, in-flight burst abandoned, no response issued.
- AW handshake in cycle N (no WLAST) → WREADY high in N+1.
- W handshake with WLAST in cycle M → BVALID high in M+1, held until BREADY.
- AR handshake in cycle N → first RVALID in N+1.
- ARLEN=L with RREADY held high → L+1 consecutive beats, RLAST on beat L, ARREADY high again the cycle after the last beat.
- RREADY low stalls: RVALID, RLAST and the beat counter hold.
- Read and write FSMs never block each other; both counters may increment in the same cycle.
- No new AW is accepted until B completes. No new AR is accepted until RLAST completes.

## Structure
- AXI_define.svh holds the shared constants: AXI_RESP_OKAY=2'b00 and AXI_RESP_DECERR=2'b11, alongside the existing width macros.
- FSM state enums are local to the module.
- One sub-module, sd_sat_cnt, parameterised by width with inc/clear inputs. It is instantiated twice, once for each error counter.

## Test plan
- AW(ID=8'h15, LEN=0) and W(WLAST=1) in the same cycle → BVALID in the next cycle with BID=8'h15, BRESP=2'b11; WR_ERR_CNT=1 after BREADY.
- AW(ID=8'h22, LEN=3), then 4 W beats with WLAST on the 4th, BREADY held low 3 cycles → BVALID held stable 3 cycles, then completes; AWREADY=0 throughout.
- AR(ID=8'h07, LEN=3), RREADY always 1 → 4 beats in consecutive cycles, RDATA=0, RRESP=2'b11, RLAST only on beat 4; RD_ERR_CNT=1.
- AR(LEN=1), RREADY toggled 1,0,1 → beat 1 in cycle 1, stall in cycle 2 with RLAST held 1, beat 2 in cycle 3.
- Concurrent AR(LEN=0) and AW+W(LAST) in the same cycle → R and B both complete; both counters reach 1 in the same cycle.
- ARESET pulsed during R_DATA of an ARLEN=7 burst → RVALID=0 at once; next AR(LEN=0) returns exactly one beat with RLAST=1.
